// File: rtl/fetch_pkg.sv
// Shared fetch-side defaults and the fetch FSM state encoding.
// Imported by the prefetch queue top and its FIFO.
package fetch_pkg;

  localparam int FQ_DEPTH   = 4;
  localparam int FQ_ADDR_W  = 32;
  localparam int FQ_INSTR_W = 32;
  localparam int FQ_PC_STEP = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0;

  typedef enum logic {
    RUN,
    REDIRECT
  } fetch_state_e;

endpackage

// File: rtl/instruction_prefetch_queue_fifo.sv
// Small {pc, instr} FIFO between the fetch port and decode.
// Flush drops everything; head outputs come straight from storage.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_ADDR_W,
  parameter int IW    = FQ_INSTR_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [AW-1:0] pc_i,
  input  logic [IW-1:0] instr_i,
  output logic          valid_o,
  output logic [AW-1:0] pc_o,
  output logic [IW-1:0] instr_o,
  output logic [CW-1:0] count_o
);

  logic [AW-1:0] pc_mem_q [DEPTH];
  logic [IW-1:0] in_mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
        in_mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) begin
        pc_mem_q[wr_q] <= pc_i;
        in_mem_q[wr_q] <= instr_i;
      end
    end
  end

  assign valid_o = (cnt_q != '0);
  assign pc_o    = pc_mem_q[rd_q];
  assign instr_o = in_mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Fetch front end: owns the PC, issues imem reads, queues
// returned words for decode and handles branch redirects.
module instruction_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = FQ_DEPTH,
  parameter int ADDR_W  = FQ_ADDR_W,
  parameter int INSTR_W = FQ_INSTR_W,
  parameter int PC_STEP = FQ_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              infl_q, infl_d;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              issue, push, pop;

  // In-flight word counts as occupied so a return always has room.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, infl_q};
  assign issue = reset & ~branch_taken
               & (occ < (CW+1)'(DEPTH));
  assign push  = infl_q & ~branch_taken & (state_q == RUN);
  assign pop   = dec_valid & dec_ready & ~branch_taken;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    infl_d  = issue;
    unique case (state_q)
      RUN:      if (branch_taken) state_d = REDIRECT;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (branch_taken) begin
      pc_d   = branch_target;
      infl_d = 1'b0;
    end else if (issue) begin
      pc_d  = pc_q + ADDR_W'(PC_STEP);
      ipc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      infl_q  <= infl_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .IW    (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (branch_taken),
    .pc_i    (ipc_q),
    .instr_i (imem_instr),
    .valid_o (dec_valid),
    .pc_o    (dec_pc),
    .instr_o (dec_instr),
    .count_o (count)
  );

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for the prefetch queue: in-order fetch, full
// stall, branch flush, PC wrap and mid-stream reset.
module tb_instruction_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_ready;
  logic        bt;
  logic [31:0] tgt;

  logic        req_a, val_a;
  logic [31:0] addr_a, ins_a, pc_a, mem_a;
  logic        req_b, val_b;
  logic [31:0] addr_b, ins_b, pc_b, mem_b;
  logic        bt_b = 1'b0;
  logic [31:0] tgt_b = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    mem_a = '0;
    mem_b = '0;
  end

  always @(posedge clk) begin
    mem_a <= f(addr_a);
    mem_b <= f(addr_b);
  end

  instruction_prefetch_queue u_a (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (req_a),
    .imem_addr     (addr_a),
    .imem_instr    (mem_a),
    .branch_taken  (bt),
    .branch_target (tgt),
    .dec_valid     (val_a),
    .dec_instr     (ins_a),
    .dec_pc        (pc_a),
    .dec_ready     (dec_ready)
  );

  instruction_prefetch_queue #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_b (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (req_b),
    .imem_addr     (addr_b),
    .imem_instr    (mem_b),
    .branch_taken  (bt_b),
    .branch_target (tgt_b),
    .dec_valid     (val_b),
    .dec_instr     (ins_b),
    .dec_pc        (pc_b),
    .dec_ready     (dec_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic rdy);
    reset = 1'b0;
    dec_ready = rdy;
    #1;
    step();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    dec_ready = 1'b1;
    bt = 1'b0;
    tgt = '0;
    step();
    step();
    chk("rst_req", 32'(req_a), 32'd0);
    chk("rst_addr", addr_a, 32'h0);
    chk("rst_valid", 32'(val_a), 32'd0);
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_instr", ins_a, 32'h0);
    chk("rst_addr_b", addr_b, 32'hFFFF_FFF8);

    // In-order streaming from reset
    reset = 1'b1;
    #1;
    chk("s_c0_req", 32'(req_a), 32'd1);
    chk("s_c0_addr", addr_a, 32'h0);
    step();
    chk("s_c1_addr", addr_a, 32'h4);
    chk("s_c1_valid", 32'(val_a), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("s_valid", 32'(val_a), 32'd1);
      chk("s_pc", pc_a, 32'(4 * k));
      chk("s_instr", ins_a, f(32'(4 * k)));
      chk("wrap_pc", pc_b, 32'hFFFF_FFF8 + 32'(4 * k));
      step();
    end

    // Back-pressure fills exactly DEPTH entries
    restart(1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("f_req", 32'(req_a), 32'd1);
      chk("f_addr", addr_a, 32'(4 * k));
      step();
    end
    chk("f_c4_req", 32'(req_a), 32'd0);
    step();
    chk("f_c5_req", 32'(req_a), 32'd0);
    chk("f_c5_addr", addr_a, 32'h10);
    dec_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("f_pop_pc", pc_a, 32'(4 * k));
      if (k == 1) begin
        chk("f_resume_req", 32'(req_a), 32'd1);
        chk("f_resume_addr", addr_a, 32'h10);
      end
      step();
    end

    // Branch with 3 queued and 1 in flight
    restart(1'b0);
    repeat (4) step();
    bt = 1'b1;
    tgt = 32'h40;
    #1;
    chk("b_req", 32'(req_a), 32'd0);
    chk("b_valid", 32'(val_a), 32'd1);
    chk("b_pc", pc_a, 32'h0);
    step();
    bt = 1'b0;
    #1;
    chk("b1_valid", 32'(val_a), 32'd0);
    chk("b1_req", 32'(req_a), 32'd1);
    chk("b1_addr", addr_a, 32'h40);
    step();
    chk("b2_valid", 32'(val_a), 32'd0);
    chk("b2_addr", addr_a, 32'h44);
    step();
    chk("b3_valid", 32'(val_a), 32'd1);
    chk("b3_pc", pc_a, 32'h40);
    chk("b3_instr", ins_a, f(32'h40));

    // Branch, pop and return all in the same cycle
    restart(1'b1);
    step();
    step();
    bt = 1'b1;
    tgt = 32'h100;
    #1;
    chk("x_req", 32'(req_a), 32'd0);
    chk("x_valid", 32'(val_a), 32'd1);
    chk("x_pc", pc_a, 32'h0);
    step();
    bt = 1'b0;
    #1;
    chk("x1_valid", 32'(val_a), 32'd0);
    chk("x1_addr", addr_a, 32'h100);
    step();
    chk("x2_valid", 32'(val_a), 32'd0);
    step();
    chk("x3_valid", 32'(val_a), 32'd1);
    chk("x3_pc", pc_a, 32'h100);
    step();
    chk("x4_pc", pc_a, 32'h104);

    // Reset pulse with a request in flight
    restart(1'b1);
    repeat (3) step();
    chk("r_pre_addr", addr_a, 32'hC);
    reset = 1'b0;
    #1;
    chk("r_valid", 32'(val_a), 32'd0);
    chk("r_req", 32'(req_a), 32'd0);
    chk("r_addr", addr_a, 32'h0);
    reset = 1'b1;
    #1;
    chk("r0_req", 32'(req_a), 32'd1);
    chk("r0_addr", addr_a, 32'h0);
    step();
    chk("r1_valid", 32'(val_a), 32'd0);
    chk("r1_addr", addr_a, 32'h4);
    step();
    chk("r2_valid", 32'(val_a), 32'd1);
    chk("r2_pc", pc_a, 32'h0);
    chk("r2_instr", ins_a, f(32'h0));
    step();
    chk("r3_pc", pc_a, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
